// File: rtl/mem_map_pkg.sv
// Address map, register offsets and shared types for the data-side memory stage.
package mem_map_pkg;

  localparam logic [31:0] REG_BASE = 32'h8000_0000;

  localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
  localparam logic [7:0] OFF_TMR_CNT  = 8'h08;
  localparam logic [7:0] OFF_TMR_CMP  = 8'h0C;
  localparam logic [7:0] OFF_TMR_CTRL = 8'h10;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLAG_BIT   = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_TMR_CNT,
    SEL_TMR_CMP,
    SEL_TMR_CTRL
  } sel_e;

  // Packed so that flag/irq_en/enable land on CTRL bits 2/1/0.
  typedef struct packed {
    logic flag;
    logic irq_en;
    logic enable;
  } tmr_ctrl_t;

  function automatic logic [31:0] reg_addr(input logic [7:0] off);
    return REG_BASE | 32'(off);
  endfunction

endpackage

// File: rtl/data_memory_io_if.sv
// MEM-stage data bus between the pipeline (master) and the memory/IO block (slave).
interface data_memory_io_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] w_data;
  logic             write_en;
  logic [WIDTH-1:0] r_data;

  modport master (output address, output w_data, output write_en, input r_data);
  modport slave  (input address, input w_data, input write_en, output r_data);
endinterface

// File: rtl/timer_unit.sv
// Compare timer: free-running counter that wraps to 0 on a compare match and
// raises a sticky W1C flag; irq is the flag gated by irq_en.
module timer_unit
  import mem_map_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cnt_we,
  input  logic             cmp_we,
  input  logic             ctrl_we,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cmp,
  output tmr_ctrl_t        ctrl,
  output logic             irq
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  tmr_ctrl_t        ctrl_q, ctrl_d;
  logic             hit;

  // Uses the registered CMP, so a CMP write only matters from the next edge on.
  assign hit = ctrl_q.enable && (cnt_q == cmp_q);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    ctrl_d = ctrl_q;

    if (ctrl_q.enable) cnt_d = hit ? '0 : cnt_q + WIDTH'(1);
    if (cnt_we)        cnt_d = w_data;
    if (cmp_we)        cmp_d = w_data;

    if (ctrl_we) begin
      ctrl_d.enable = w_data[CTRL_EN_BIT];
      ctrl_d.irq_en = w_data[CTRL_IRQ_EN_BIT];
      if (w_data[CTRL_FLAG_BIT]) ctrl_d.flag = 1'b0;
    end
    // Hardware set is applied last so it wins over a same-cycle W1C.
    if (hit) ctrl_d.flag = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      cmp_q  <= '0;
      ctrl_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign cnt  = cnt_q;
  assign cmp  = cmp_q;
  assign ctrl = ctrl_q;
  assign irq  = ctrl_q.flag & ctrl_q.irq_en;

endmodule

// File: rtl/data_memory_io.sv
// Data-side memory stage: word RAM, GPIO with input synchroniser, compare timer,
// combinational read mux and a sticky bus_error for unmapped/misaligned accesses.
module data_memory_io
  import mem_map_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int GPIO_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  data_memory_io_if.slave   bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_error
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     ram_idx;
  sel_e              sel;
  logic              ram_we, gpio_we, cnt_we, cmp_we, ctrl_we;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d;
  logic [GPIO_W-1:0] sync2_q, sync2_d;
  logic              bus_error_q, bus_error_d;
  logic [WIDTH-1:0]  tmr_cnt, tmr_cmp;
  tmr_ctrl_t         tmr_ctrl;
  logic [WIDTH-1:0]  rd_data;

  assign ram_idx = bus.address[AW+1:2];

  // Misaligned addresses fall through to SEL_NONE like any unmapped address.
  always_comb begin
    sel = SEL_NONE;
    if (bus.address[1:0] == 2'b00) begin
      if (bus.address[WIDTH-1:AW+2] == '0)                        sel = SEL_RAM;
      else if (bus.address == WIDTH'(reg_addr(OFF_GPIO_OUT)))     sel = SEL_GPIO_OUT;
      else if (bus.address == WIDTH'(reg_addr(OFF_GPIO_IN)))      sel = SEL_GPIO_IN;
      else if (bus.address == WIDTH'(reg_addr(OFF_TMR_CNT)))      sel = SEL_TMR_CNT;
      else if (bus.address == WIDTH'(reg_addr(OFF_TMR_CMP)))      sel = SEL_TMR_CMP;
      else if (bus.address == WIDTH'(reg_addr(OFF_TMR_CTRL)))     sel = SEL_TMR_CTRL;
    end
  end

  assign ram_we  = bus.write_en && (sel == SEL_RAM);
  assign gpio_we = bus.write_en && (sel == SEL_GPIO_OUT);
  assign cnt_we  = bus.write_en && (sel == SEL_TMR_CNT);
  assign cmp_we  = bus.write_en && (sel == SEL_TMR_CMP);
  assign ctrl_we = bus.write_en && (sel == SEL_TMR_CTRL);

  // NOTE: the RAM array has no reset; contents survive reset and map onto plain block RAM.
  always_ff @(posedge clock) begin
    if (ram_we) mem_q[ram_idx] <= bus.w_data;
  end

  always_comb begin
    gpio_out_d  = gpio_out_q;
    if (gpio_we) gpio_out_d = bus.w_data[GPIO_W-1:0];
    sync1_d     = gpio_in;
    sync2_d     = sync1_q;
    // Every cycle is an access (no read strobe), so a stray address is flagged too.
    bus_error_d = bus_error_q | (sel == SEL_NONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpio_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      bus_error_q <= bus_error_d;
    end
  end

  timer_unit #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .cnt_we  (cnt_we),
    .cmp_we  (cmp_we),
    .ctrl_we (ctrl_we),
    .w_data  (bus.w_data),
    .cnt     (tmr_cnt),
    .cmp     (tmr_cmp),
    .ctrl    (tmr_ctrl),
    .irq     (timer_irq)
  );

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_RAM:      rd_data = mem_q[ram_idx];
      SEL_GPIO_OUT: rd_data = WIDTH'(gpio_out_q);
      SEL_GPIO_IN:  rd_data = WIDTH'(sync2_q);
      SEL_TMR_CNT:  rd_data = tmr_cnt;
      SEL_TMR_CMP:  rd_data = tmr_cmp;
      SEL_TMR_CTRL: rd_data = WIDTH'(tmr_ctrl);
      default:      rd_data = '0;
    endcase
  end

  assign bus.r_data = rd_data;
  assign gpio_out   = gpio_out_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Directed and randomized checks of data_memory_io against a behavioural model
// of the address map, GPIO synchroniser, compare timer and sticky bus_error.
module tb_data_memory_io;

  localparam logic [31:0] A_GOUT = 32'h8000_0000;
  localparam logic [31:0] A_GIN  = 32'h8000_0004;
  localparam logic [31:0] A_CNT  = 32'h8000_0008;
  localparam logic [31:0] A_CMP  = 32'h8000_000C;
  localparam logic [31:0] A_CTRL = 32'h8000_0010;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;
  logic       bus_error;

  int total = 0;
  int bad   = 0;

  data_memory_io_if #(.WIDTH(32)) bus ();

  data_memory_io #(
    .WIDTH  (32),
    .DEPTH  (256),
    .GPIO_W (8)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_error (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0] ram_m [256];
  bit          ram_k [256];
  logic [7:0]  gout_m;
  logic [7:0]  gin_h1, gin_h2;   // gpio_in as sampled one and two edges ago
  logic [31:0] cnt_m, cmp_m;
  logic        en_m, ie_m, flag_m, berr_m;

  function automatic bit mapped(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a < 32'd1024) || ((a >= A_GOUT) && (a <= A_CTRL)));
  endfunction

  function automatic logic [31:0] cnt_next(input logic [31:0] a, input logic [31:0] w, input logic we);
    if (we && a == A_CNT) return w;
    if (!en_m) return cnt_m;
    return (cnt_m == cmp_m) ? 32'd0 : cnt_m + 32'd1;
  endfunction

  function automatic logic flag_next(input logic [31:0] a, input logic [31:0] w, input logic we);
    if (en_m && cnt_m == cmp_m) return 1'b1;
    if (we && a == A_CTRL && w[2]) return 1'b0;
    return flag_m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gout_m <= '0; gin_h1 <= '0; gin_h2 <= '0;
      cnt_m  <= '0; cmp_m  <= '0;
      en_m   <= 1'b0; ie_m <= 1'b0; flag_m <= 1'b0; berr_m <= 1'b0;
    end else begin
      gin_h1 <= gpio_in;
      gin_h2 <= gin_h1;
      cnt_m  <= cnt_next(bus.address, bus.w_data, bus.write_en);
      flag_m <= flag_next(bus.address, bus.w_data, bus.write_en);
      if (!mapped(bus.address)) berr_m <= 1'b1;
      else if (bus.write_en) begin
        if (bus.address < 32'd1024) begin
          ram_m[bus.address[9:2]] <= bus.w_data;
          ram_k[bus.address[9:2]] <= 1'b1;
        end else if (bus.address == A_GOUT) gout_m <= bus.w_data[7:0];
        else if (bus.address == A_CMP) cmp_m <= bus.w_data;
        else if (bus.address == A_CTRL) begin
          en_m <= bus.w_data[0];
          ie_m <= bus.w_data[1];
        end
      end
    end
  end

  function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output bit k);
    v = '0;
    k = 1'b1;
    if (!mapped(a)) return;
    if (a < 32'd1024) begin
      v = ram_m[a[9:2]];
      k = ram_k[a[9:2]];
    end else if (a == A_GOUT) v = 32'(gout_m);
    else if (a == A_GIN)  v = 32'(gin_h2);
    else if (a == A_CNT)  v = cnt_m;
    else if (a == A_CMP)  v = cmp_m;
    else                  v = {29'd0, flag_m, ie_m, en_m};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.address  = a;
    bus.w_data   = d;
    bus.write_en = we;
  endtask

  // One rising edge, then settle into the low phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_read(input string tag);
    logic [31:0] v;
    bit          k;
    #1;
    model_read(bus.address, v, k);
    if (k) check(tag, bus.r_data, v);
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_gpio_out"},  32'(gpio_out),  32'(gout_m));
    check({tag, "_timer_irq"}, 32'(timer_irq), 32'(flag_m & ie_m));
    check({tag, "_bus_error"}, 32'(bus_error), 32'(berr_m));
  endtask

  task automatic wait_hit(input string tag);
    int n;
    n = 0;
    while (cnt_m != cmp_m && n < 20) begin
      drive(A_CNT, 32'd0, 1'b0);
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 20), 32'd1);
  endtask

  task automatic random_phase(input int n, input bit allow_bad);
    logic [31:0] a, d;
    logic        we;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      d = $urandom;
      if (r < 5) a = 32'($urandom_range(8, 63)) * 32'd4;
      else if (r == 5) a = A_GOUT;
      else if (r == 6) a = A_GIN;
      else if (r == 7) begin a = A_CNT; d = 32'($urandom_range(0, 12)); end
      else if (r == 8) begin a = A_CMP; d = 32'($urandom_range(0, 12)); end
      else a = A_CTRL;
      if (allow_bad && $urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 0) ? (a | 32'd1) : (32'h4000_0000 + 32'($urandom_range(0, 255)) * 32'd4);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      drive(a, d, we);
      check_read("rand_rd");
      tick();
      check_pins("rand");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_cnt [5];
    logic        exp_irq [5];
    exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst     = 1'b1;
    gpio_in = 8'h00;
    drive(A_CNT, 32'd0, 1'b0);
    #3;
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_timer_irq", 32'(timer_irq), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_cnt", bus.r_data, 32'd0);
    #9;
    rst = 1'b0;
    @(negedge clk);
    #1;

    // RAM write then same-cycle combinational read
    drive(32'h14, 32'h1234_5678, 1'b1); tick();
    drive(32'h00, 32'h1111_1111, 1'b1); tick();
    drive(32'h10, 32'hDEAD_BEEF, 1'b1); tick();
    drive(32'h10, 32'd0, 1'b0); #1;
    check("ram_rd_10", bus.r_data, 32'hDEAD_BEEF);
    drive(32'h14, 32'd0, 1'b0); #1;
    check("ram_rd_14_unaffected", bus.r_data, 32'h1234_5678);

    // GPIO out and 2-flop input synchroniser
    drive(A_GOUT, 32'hFFFF_FFA5, 1'b1); tick();
    check("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);
    drive(A_GOUT, 32'd0, 1'b0); #1;
    check("gpio_out_rd_upper0", bus.r_data, 32'h0000_00A5);
    gpio_in = 8'h3C;
    drive(A_GIN, 32'd0, 1'b0); #1;
    check("gpio_in_0_edges", bus.r_data, 32'h0);
    tick();
    check("gpio_in_1_edge", bus.r_data, 32'h0);
    tick();
    check("gpio_in_2_edges", bus.r_data, 32'h3C);
    check_pins("gpio");

    // Timer: CMP=3, enable + irq_en, count 0..3 then wrap with flag
    drive(A_CMP, 32'd3, 1'b1); tick();
    drive(A_CTRL, 32'd3, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(A_CNT, 32'd0, 1'b0); #1;
      check("tmr_cnt_seq", bus.r_data, exp_cnt[i]);
      check("tmr_irq_seq", 32'(timer_irq), 32'(exp_irq[i]));
      tick();
    end
    drive(A_CTRL, 32'd7, 1'b1); tick();
    check("tmr_w1c_clears", 32'(timer_irq), 32'd0);
    drive(A_CTRL, 32'd0, 1'b0); #1;
    check("tmr_ctrl_rd", bus.r_data, 32'd3);

    // CNT write beats the wrap; hardware flag set beats W1C
    wait_hit("hit1");
    drive(A_CNT, 32'd100, 1'b1); tick();
    drive(A_CNT, 32'd0, 1'b0); #1;
    check("cnt_write_beats_wrap", bus.r_data, 32'd100);
    drive(A_CNT, 32'd0, 1'b1); tick();
    drive(A_CTRL, 32'd7, 1'b1); tick();
    check("flag_cleared_again", 32'(timer_irq), 32'd0);
    wait_hit("hit2");
    drive(A_CTRL, 32'd7, 1'b1); tick();
    check("set_beats_w1c", 32'(timer_irq), 32'd1);
    check_pins("set_beats_w1c");

    random_phase(300, 1'b0);

    // Unmapped and misaligned accesses
    check("berr_clean_so_far", 32'(bus_error), 32'd0);
    drive(32'h4000_0000, 32'd0, 1'b0); #1;
    check("unmapped_rd_zero", bus.r_data, 32'd0);
    tick();
    check("unmapped_sets_berr", 32'(bus_error), 32'd1);
    drive(32'h0000_0002, 32'hFFFF_FFFF, 1'b1); #1;
    check("misaligned_rd_zero", bus.r_data, 32'd0);
    tick();
    drive(32'h0, 32'd0, 1'b0); #1;
    check("misaligned_wr_ignored", bus.r_data, 32'h1111_1111);
    tick();
    check("berr_sticky", 32'(bus_error), 32'd1);

    random_phase(200, 1'b1);

    // Reset mid-count with flag, irq, gpio_out and bus_error all set
    drive(A_GOUT, 32'hA5, 1'b1); tick();
    drive(A_CTRL, 32'd0, 1'b1); tick();
    drive(A_CNT, 32'd0, 1'b1); tick();
    drive(A_CMP, 32'd0, 1'b1); tick();
    drive(A_CTRL, 32'd3, 1'b1); tick();
    drive(A_CNT, 32'd0, 1'b0); tick();
    drive(A_CMP, 32'd100, 1'b1); tick();
    drive(A_CNT, 32'd0, 1'b0); tick(); tick();
    check("pre_rst_cnt2", bus.r_data, 32'd2);
    check("pre_rst_irq", 32'(timer_irq), 32'd1);
    check("pre_rst_gpio", 32'(gpio_out), 32'hA5);
    check("pre_rst_berr", 32'(bus_error), 32'd1);
    gpio_in = 8'h5A;
    rst = 1'b1;
    #1;
    check("async_rst_gpio_out", 32'(gpio_out), 32'd0);
    check("async_rst_irq", 32'(timer_irq), 32'd0);
    check("async_rst_berr", 32'(bus_error), 32'd0);
    check("async_rst_cnt", bus.r_data, 32'd0);
    drive(A_CMP, 32'd0, 1'b0); #1;
    check("async_rst_cmp", bus.r_data, 32'd0);
    drive(A_CTRL, 32'd0, 1'b0); #1;
    check("async_rst_ctrl", bus.r_data, 32'd0);
    drive(A_GIN, 32'd0, 1'b0); #1;
    check("async_rst_sync", bus.r_data, 32'd0);
    drive(32'h10, 32'd0, 1'b0); #1;
    check("ram_kept_over_rst", bus.r_data, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tick();
    check_pins("post_rst");
    drive(32'h14, 32'd0, 1'b0);
    check_read("post_rst_ram14");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
